// File: rtl/cam_types_pkg.sv
// cam_types: shared types for the key/value CAM with true-LRU replacement.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Holds the default geometry, key/val/idx types, entry struct and request encoding.
package cam_types;

    localparam int camsize_p   = 8;
    localparam int key_width_p = 16;
    localparam int val_width_p = 16;
    localparam int idx_width_p = $clog2(camsize_p);

    typedef logic [key_width_p-1:0] key_t;
    typedef logic [val_width_p-1:0] val_t;
    typedef logic [idx_width_p-1:0] idx_t;

    typedef struct packed {
        logic valid;
        key_t key;
        val_t val;
    } entry_t;

    // Encoding matches the rw_n_i pin: 1 = read, 0 = write.
    typedef enum logic {
        CAM_WRITE = 1'b0,
        CAM_READ  = 1'b1
    } cam_req_e;

endpackage

// File: rtl/cam_lru_ages.sv
// cam_lru_ages: true-LRU age registers; age 0 = most recent, camsize_p-1 = victim.
// Latency: ages update at the edge after acc_i; victim_idx_o is combinational from current ages.
// Backpressure: none; accepts one access per cycle.
// Ports: clk, rst (sync, active-high), acc_i/acc_idx_i (access strobe and entry), victim_idx_o.
module cam_lru_ages
    import cam_types::*;
#(
    parameter int camsize_p = 8,
    localparam int IW       = $clog2(camsize_p)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          acc_i,
    input  logic [IW-1:0] acc_idx_i,
    output logic [IW-1:0] victim_idx_o
);

    logic [IW-1:0] age_q [camsize_p];
    logic [IW-1:0] age_d [camsize_p];

    // Entries younger than the accessed one age by one; the accessed one becomes
    // youngest. This keeps the ages a permutation of 0..camsize_p-1.
    always_comb begin
        age_d = age_q;
        if (acc_i) begin
            for (int j = 0; j < camsize_p; j++) begin
                if (age_q[j] < age_q[acc_idx_i]) begin
                    age_d[j] = age_q[j] + 1'b1;
                end
            end
            age_d[acc_idx_i] = '0;
        end
    end

    always_comb begin
        victim_idx_o = '0;
        for (int j = 0; j < camsize_p; j++) begin
            if (age_q[j] == IW'(camsize_p - 1)) begin
                victim_idx_o = IW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < camsize_p; j++) begin
                age_q[j] <= IW'(j);
            end
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/cam_lru_store.sv
// cam_lru_store: fully-associative key/value CAM with true-LRU replacement.
// Latency: read response, evict pulse and idx one cycle after the request.
// Backpressure: none; one request accepted every cycle.
// Ports: clk, rst (sync, active-high), valid_i/rw_n_i/key_i/val_i request,
//        valid_o/hit_o/val_o read response, evict_o pulse, idx_o last touched entry.
// Optional: CAM_STATS_EN adds stat_hits_o, stat_miss_o, stat_evicts_o (32-bit, saturating).
module cam_lru_store
    import cam_types::*;
#(
    parameter int camsize_p   = 8,
    parameter int key_width_p = 16,
    parameter int val_width_p = 16,
    localparam int IW         = $clog2(camsize_p)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic                   rw_n_i,
    input  logic [key_width_p-1:0] key_i,
    input  logic [val_width_p-1:0] val_i,
    output logic                   valid_o,
    output logic                   hit_o,
    output logic [val_width_p-1:0] val_o,
    output logic                   evict_o,
`ifdef CAM_STATS_EN
    output logic [31:0]            stat_hits_o,
    output logic [31:0]            stat_miss_o,
    output logic [31:0]            stat_evicts_o,
`endif
    output logic [IW-1:0]          idx_o
);

    // Same layout as cam_types::entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic                   valid;
        logic [key_width_p-1:0] key;
        logic [val_width_p-1:0] val;
    } ent_t;

    ent_t ent_q [camsize_p];
    ent_t ent_d [camsize_p];

    logic                   valid_q, valid_d;
    logic                   hit_q, hit_d;
    logic [val_width_p-1:0] val_q, val_d;
    logic                   evict_q, evict_d;
    logic [IW-1:0]          idx_q, idx_d;

    logic                 hit, full, is_rd, acc;
    logic [IW-1:0]        hit_idx, free_idx, victim_idx, acc_idx;
    logic [camsize_p-1:0] match_vec;

    assign is_rd = (cam_req_e'(rw_n_i) == CAM_READ);

    // Lookup against the current (post-previous-edge) array, so a write followed
    // by an access to the same key always sees the committed entry.
    always_comb begin
        match_vec = '0;
        hit       = 1'b0;
        hit_idx   = '0;
        for (int i = 0; i < camsize_p; i++) begin
            match_vec[i] = ent_q[i].valid && (ent_q[i].key == key_i);
            if (match_vec[i]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    // Downward scan so the lowest-index invalid entry wins.
    always_comb begin
        full     = 1'b1;
        free_idx = '0;
        for (int i = camsize_p - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) begin
                full     = 1'b0;
                free_idx = IW'(i);
            end
        end
    end

    always_comb begin
        ent_d   = ent_q;
        acc     = 1'b0;
        acc_idx = hit_idx;
        valid_d = 1'b0;
        hit_d   = 1'b0;
        val_d   = '0;
        evict_d = 1'b0;
        idx_d   = idx_q;   // idx only moves when an entry is touched
        if (valid_i) begin
            if (is_rd) begin
                valid_d = 1'b1;
                if (hit) begin
                    hit_d = 1'b1;
                    val_d = ent_q[hit_idx].val;
                    idx_d = hit_idx;
                    acc   = 1'b1;
                end
            end else begin
                if (hit) begin
                    acc_idx = hit_idx;
                end else if (!full) begin
                    acc_idx = free_idx;
                end else begin
                    acc_idx = victim_idx;
                    evict_d = 1'b1;
                end
                acc            = 1'b1;
                idx_d          = acc_idx;
                ent_d[acc_idx] = '{valid: 1'b1, key: key_i, val: val_i};
            end
        end
    end

    cam_lru_ages #(
        .camsize_p (camsize_p)
    ) u_ages (
        .clk          (clk),
        .rst          (rst),
        .acc_i        (acc),
        .acc_idx_i    (acc_idx),
        .victim_idx_o (victim_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < camsize_p; i++) begin
                ent_q[i] <= '0;
            end
            valid_q <= 1'b0;
            hit_q   <= 1'b0;
            val_q   <= '0;
            evict_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            ent_q   <= ent_d;
            valid_q <= valid_d;
            hit_q   <= hit_d;
            val_q   <= val_d;
            evict_q <= evict_d;
            idx_q   <= idx_d;
        end
    end

    assign valid_o = valid_q;
    assign hit_o   = hit_q;
    assign val_o   = val_q;
    assign evict_o = evict_q;
    assign idx_o   = idx_q;

`ifdef CAM_STATS_EN
    logic [31:0] hits_q, miss_q, evicts_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q   <= '0;
            miss_q   <= '0;
            evicts_q <= '0;
        end else if (valid_i) begin
            if (hit && hits_q != '1) begin
                hits_q <= hits_q + 32'd1;
            end
            if (is_rd && !hit && miss_q != '1) begin
                miss_q <= miss_q + 32'd1;
            end
            if (evict_d && evicts_q != '1) begin
                evicts_q <= evicts_q + 32'd1;
            end
        end
    end

    assign stat_hits_o   = hits_q;
    assign stat_miss_o   = miss_q;
    assign stat_evicts_o = evicts_q;
`endif

endmodule
